// File: rtl/mips_mem_arbiter_pkg.sv
// Shared definitions for the mips_32 unified-memory arbiter: default widths,
// port identifiers and the response tag layout carried through the tag pipe.
package mips_mem_arbiter_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF     = 32;
  localparam int MEM_LAT_DEF    = 1;
  localparam int STARVE_MAX_DEF = 4;

  localparam logic PORT_IF = 1'b1;
  localparam logic PORT_D  = 1'b0;

  // Tag of one issued access. valid marks a read, port names the requester.
  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  function automatic logic tag_is_port(input tag_t t, input logic p);
    return t.valid & (t.port == p);
  endfunction

endpackage

// File: rtl/mips_rsp_tag_pipe.sv
// Fixed-depth shift register of response tags. The last stage lines up with the
// memory read data; the any-valid flag reports that a read is still in flight.
module mips_rsp_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic         o_any_valid
);

  logic [W-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

  // The valid flag is the MSB of every stage.
  always_comb begin
    o_any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) o_any_valid = o_any_valid | r_pipe[i][W-1];
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter between the IF fetch port and the MEM load/store port,
// with fetch anti-starvation, halt gating and latency-matched read response routing.
module mips_mem_arbiter
  import mips_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  // Both request ports: req is held with its payload until the matching gnt.
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_SAT = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]  r_starve_cnt;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_eff_if;
  logic              w_starved;
  logic              w_if_gnt;
  logic              w_d_gnt;
  tag_t              w_tag_in;
  tag_t              w_tag_out;
  logic [TAG_W-1:0]  w_tag_out_bits;
  logic              w_busy;
  logic              w_if_rvalid;
  logic              w_d_rvalid;

  // Grants are gated by rst_n so every output is 0 while reset is asserted.
  assign w_eff_if  = if_req & ~halt;
  assign w_starved = (r_starve_cnt == STARVE_SAT);
  assign w_if_gnt  = rst_n & w_eff_if & (~d_req | w_starved);
  assign w_d_gnt   = rst_n & d_req & ~w_if_gnt;

  assign if_gnt = w_if_gnt;
  assign d_gnt  = w_d_gnt;
  assign mem_en = w_if_gnt | w_d_gnt;
  assign mem_we = w_d_gnt & d_we;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_if_gnt) begin
      mem_addr = if_addr;
    end else if (w_d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!w_eff_if || w_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (!w_starved) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Stores complete at grant, so only reads enter the tag pipe as valid.
  always_comb begin
    w_tag_in.valid = mem_en & ~mem_we;
    w_tag_in.port  = w_if_gnt ? PORT_IF : PORT_D;
  end

  mips_rsp_tag_pipe #(
    .DEPTH (MEM_LAT),
    .W     (TAG_W)
  ) u_tag_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_d         (w_tag_in),
    .o_q         (w_tag_out_bits),
    .o_any_valid (w_busy)
  );

  assign w_tag_out  = tag_t'(w_tag_out_bits);
  assign w_if_rvalid = tag_is_port(w_tag_out, PORT_IF);
  assign w_d_rvalid  = tag_is_port(w_tag_out, PORT_D);
  assign if_rvalid  = w_if_rvalid;
  assign d_rvalid   = w_d_rvalid;
  assign busy       = w_busy;

  // Read data passes straight through on its response cycle and is held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_if_rvalid) r_if_rdata <= mem_rdata;
      if (w_d_rvalid)  r_d_rdata  <= mem_rdata;
    end
  end

  assign if_rdata = w_if_rvalid ? mem_rdata : r_if_rdata;
  assign d_rdata  = w_d_rvalid  ? mem_rdata : r_d_rdata;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3, each
// attached to a write-first memory model preloaded with mem[a]=a+100.
module tb_mips_mem_arbiter;

  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // ---------------- instance A: MEM_LAT=1 ----------------
  logic        a_halt, a_if_req, a_d_req, a_d_we;
  logic [9:0]  a_if_addr, a_d_addr;
  logic [31:0] a_d_wdata;
  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid;
  logic [31:0] a_if_rdata, a_d_rdata;
  logic        a_mem_en, a_mem_we, a_busy;
  logic [9:0]  a_mem_addr;
  logic [31:0] a_mem_wdata, a_mem_rdata;

  mips_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .halt(a_halt),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  // ---------------- instance B: MEM_LAT=3 ----------------
  logic        b_halt, b_if_req, b_d_req, b_d_we;
  logic [9:0]  b_if_addr, b_d_addr;
  logic [31:0] b_d_wdata;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid;
  logic [31:0] b_if_rdata, b_d_rdata;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [9:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;

  mips_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .halt(b_halt),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // ---------------- memory models (write-first) ----------------
  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  logic [31:0] rp_b [3];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 32'(i + 100);
      mem_b[i] = 32'(i + 100);
    end
    a_mem_rdata = '0;
    for (int i = 0; i < 3; i++) rp_b[i] = '0;
  end

  always @(posedge clk) begin
    if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
    if (a_mem_en && !a_mem_we) a_mem_rdata <= mem_a[a_mem_addr];
  end

  always @(posedge clk) begin
    if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
    rp_b[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr] : 32'd0;
    rp_b[1] <= rp_b[0];
    rp_b[2] <= rp_b[1];
  end

  assign b_mem_rdata = rp_b[2];

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_halt = 0; a_if_req = 0; a_if_addr = '0;
    a_d_req = 0; a_d_we = 0; a_d_addr = '0; a_d_wdata = '0;
  endtask

  task automatic b_idle();
    b_halt = 0; b_if_req = 0; b_if_addr = '0;
    b_d_req = 0; b_d_we = 0; b_d_addr = '0; b_d_wdata = '0;
  endtask

  task automatic a_load(input logic [9:0] addr);
    a_d_req = 1; a_d_we = 0; a_d_addr = addr;
  endtask

  task automatic b_check_all_zero(input string tag);
    chk({tag, "_if_gnt"},    32'(b_if_gnt),    32'd0);
    chk({tag, "_d_gnt"},     32'(b_d_gnt),     32'd0);
    chk({tag, "_mem_en"},    32'(b_mem_en),    32'd0);
    chk({tag, "_mem_we"},    32'(b_mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(b_mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, b_mem_wdata,      32'd0);
    chk({tag, "_if_rvalid"}, 32'(b_if_rvalid), 32'd0);
    chk({tag, "_d_rvalid"},  32'(b_d_rvalid),  32'd0);
    chk({tag, "_if_rdata"},  b_if_rdata,       32'd0);
    chk({tag, "_d_rdata"},   b_d_rdata,        32'd0);
    chk({tag, "_busy"},      32'(b_busy),      32'd0);
  endtask

  // ---------------- single-cycle grant vectors ----------------
  typedef struct {
    logic        halt;
    logic        if_req;
    logic [9:0]  if_addr;
    logic        d_req;
    logic        d_we;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_en;
    logic        e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    // halt, if_req, if_addr, d_req, d_we, d_addr, d_wdata | if_gnt, d_gnt, en, we, addr, wdata
    vecs[0] = '{1'b0, 1'b1, 10'd5,  1'b0, 1'b0, 10'd0,  32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 10'd5,  32'h0};
    vecs[1] = '{1'b0, 1'b0, 10'd0,  1'b1, 1'b0, 10'd7,  32'h1234, 1'b0, 1'b1, 1'b1, 1'b0, 10'd7,  32'h1234};
    vecs[2] = '{1'b0, 1'b0, 10'd0,  1'b1, 1'b1, 10'd20, 32'hABCD, 1'b0, 1'b1, 1'b1, 1'b1, 10'd20, 32'hABCD};
    vecs[3] = '{1'b0, 1'b1, 10'd3,  1'b1, 1'b0, 10'd8,  32'h55,   1'b0, 1'b1, 1'b1, 1'b0, 10'd8,  32'h55};
    vecs[4] = '{1'b1, 1'b1, 10'd4,  1'b0, 1'b0, 10'd0,  32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 10'd0,  32'h0};
    vecs[5] = '{1'b1, 1'b1, 10'd4,  1'b1, 1'b1, 10'd30, 32'h77,   1'b0, 1'b1, 1'b1, 1'b1, 10'd30, 32'h77};
    vecs[6] = '{1'b0, 1'b0, 10'd9,  1'b0, 1'b1, 10'd9,  32'h99,   1'b0, 1'b0, 1'b0, 1'b0, 10'd0,  32'h0};
    vecs[7] = '{1'b0, 1'b1, 10'd1023, 1'b0, 1'b1, 10'd2, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 10'd1023, 32'h0};
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 0;
    a_idle();
    b_idle();

    // Reset state, with requests asserted to show grants are held off.
    #2;
    b_if_req = 1; b_d_req = 1; b_d_addr = 10'd3; b_d_wdata = 32'h11;
    #1;
    b_check_all_zero("reset");
    b_idle();
    next_cycle();
    next_cycle();
    rst_n = 1;
    next_cycle();

    // Test 1: single fetch, response one cycle later.
    a_if_req = 1; a_if_addr = 10'd5;
    @(negedge clk);
    chk("t1_if_gnt",   32'(a_if_gnt),   32'd1);
    chk("t1_mem_addr", 32'(a_mem_addr), 32'd5);
    chk("t1_busy0",    32'(a_busy),     32'd0);
    next_cycle();
    a_idle();
    @(negedge clk);
    chk("t1_if_rvalid", 32'(a_if_rvalid), 32'd1);
    chk("t1_if_rdata",  a_if_rdata,       32'd105);
    chk("t1_busy1",     32'(a_busy),      32'd1);
    next_cycle();
    @(negedge clk);
    chk("t1_if_rvalid_off", 32'(a_if_rvalid), 32'd0);
    chk("t1_if_rdata_hold", a_if_rdata,       32'd105);
    next_cycle();

    // Table: one vector per cycle, each followed by an idle cycle.
    for (int i = 0; i < 8; i++) begin
      a_halt = vecs[i].halt; a_if_req = vecs[i].if_req; a_if_addr = vecs[i].if_addr;
      a_d_req = vecs[i].d_req; a_d_we = vecs[i].d_we;
      a_d_addr = vecs[i].d_addr; a_d_wdata = vecs[i].d_wdata;
      @(negedge clk);
      chk($sformatf("vec%0d_if_gnt", i),    32'(a_if_gnt),    32'(vecs[i].e_if_gnt));
      chk($sformatf("vec%0d_d_gnt", i),     32'(a_d_gnt),     32'(vecs[i].e_d_gnt));
      chk($sformatf("vec%0d_mem_en", i),    32'(a_mem_en),    32'(vecs[i].e_en));
      chk($sformatf("vec%0d_mem_we", i),    32'(a_mem_we),    32'(vecs[i].e_we));
      chk($sformatf("vec%0d_mem_addr", i),  32'(a_mem_addr),  32'(vecs[i].e_addr));
      chk($sformatf("vec%0d_mem_wdata", i), a_mem_wdata,      vecs[i].e_wdata);
      next_cycle();
      a_idle();
      next_cycle();
    end

    // Test 2: both ports held -> 4 data grants then one fetch grant, repeating.
    a_if_req = 1; a_if_addr = 10'd3;
    a_load(10'd7);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("t2_c%0d_if_gnt", c), 32'(a_if_gnt), (c % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("t2_c%0d_d_gnt", c),  32'(a_d_gnt),  (c % 5 == 4) ? 32'd0 : 32'd1);
      chk($sformatf("t2_c%0d_addr", c),   32'(a_mem_addr), (c % 5 == 4) ? 32'd3 : 32'd7);
      next_cycle();
    end
    a_idle();
    next_cycle();

    // Test 3: store then load to the same address in the next cycle.
    a_d_req = 1; a_d_we = 1; a_d_addr = 10'd9; a_d_wdata = 32'hDEAD;
    @(negedge clk);
    chk("t3_st_gnt", 32'(a_d_gnt),  32'd1);
    chk("t3_st_we",  32'(a_mem_we), 32'd1);
    next_cycle();
    a_d_we = 0; a_d_wdata = '0;
    @(negedge clk);
    chk("t3_ld_gnt",        32'(a_d_gnt),    32'd1);
    chk("t3_no_st_rvalid",  32'(a_d_rvalid), 32'd0);
    next_cycle();
    a_idle();
    @(negedge clk);
    chk("t3_ld_rvalid", 32'(a_d_rvalid), 32'd1);
    chk("t3_ld_rdata",  a_d_rdata,       32'hDEAD);
    next_cycle();
    @(negedge clk);
    chk("t3_rvalid_off", 32'(a_d_rvalid), 32'd0);
    chk("t3_rdata_hold", a_d_rdata,       32'hDEAD);
    next_cycle();

    // Test 4: two fetches in flight, then halt; fetch responses still return.
    a_if_req = 1; a_if_addr = 10'd1;
    @(negedge clk);
    chk("t4_gnt1", 32'(a_if_gnt), 32'd1);
    next_cycle();
    a_if_addr = 10'd2;
    @(negedge clk);
    chk("t4_gnt2",    32'(a_if_gnt),    32'd1);
    chk("t4_rvalid1", 32'(a_if_rvalid), 32'd1);
    chk("t4_rdata1",  a_if_rdata,       32'd101);
    next_cycle();
    a_halt = 1; a_if_addr = 10'd3;
    a_load(10'd7);
    @(negedge clk);
    chk("t4_halt_if_gnt", 32'(a_if_gnt),    32'd0);
    chk("t4_halt_d_gnt",  32'(a_d_gnt),     32'd1);
    chk("t4_rvalid2",     32'(a_if_rvalid), 32'd1);
    chk("t4_rdata2",      a_if_rdata,       32'd102);
    next_cycle();
    a_d_req = 0;
    @(negedge clk);
    chk("t4_halt_if_gnt2", 32'(a_if_gnt),   32'd0);
    chk("t4_halt_mem_en",  32'(a_mem_en),   32'd0);
    chk("t4_d_rvalid",     32'(a_d_rvalid), 32'd1);
    chk("t4_d_rdata",      a_d_rdata,       32'd107);
    next_cycle();
    @(negedge clk);
    chk("t4_halt_if_gnt3", 32'(a_if_gnt), 32'd0);
    next_cycle();
    a_idle();
    next_cycle();

    // Test 5: MEM_LAT=3, alternating ports, responses routed 3 cycles later.
    b_if_req = 1; b_if_addr = 10'd10;
    @(negedge clk);
    chk("t5_c0_if_gnt", 32'(b_if_gnt), 32'd1);
    chk("t5_c0_busy",   32'(b_busy),   32'd0);
    next_cycle();
    b_if_req = 0; b_d_req = 1; b_d_we = 0; b_d_addr = 10'd11;
    @(negedge clk);
    chk("t5_c1_d_gnt", 32'(b_d_gnt), 32'd1);
    chk("t5_c1_busy",  32'(b_busy),  32'd1);
    next_cycle();
    b_d_req = 0; b_if_req = 1; b_if_addr = 10'd12;
    @(negedge clk);
    chk("t5_c2_if_gnt", 32'(b_if_gnt),    32'd1);
    chk("t5_c2_busy",   32'(b_busy),      32'd1);
    chk("t5_c2_no_rsp", 32'(b_if_rvalid), 32'd0);
    next_cycle();
    b_idle();
    @(negedge clk);
    chk("t5_c3_if_rvalid", 32'(b_if_rvalid), 32'd1);
    chk("t5_c3_if_rdata",  b_if_rdata,       32'd110);
    chk("t5_c3_d_rvalid",  32'(b_d_rvalid),  32'd0);
    chk("t5_c3_busy",      32'(b_busy),      32'd1);
    next_cycle();
    @(negedge clk);
    chk("t5_c4_d_rvalid",  32'(b_d_rvalid),  32'd1);
    chk("t5_c4_d_rdata",   b_d_rdata,        32'd111);
    chk("t5_c4_if_rvalid", 32'(b_if_rvalid), 32'd0);
    chk("t5_c4_busy",      32'(b_busy),      32'd1);
    next_cycle();
    @(negedge clk);
    chk("t5_c5_if_rvalid", 32'(b_if_rvalid), 32'd1);
    chk("t5_c5_if_rdata",  b_if_rdata,       32'd112);
    chk("t5_c5_busy",      32'(b_busy),      32'd1);
    next_cycle();
    @(negedge clk);
    chk("t5_c6_busy",       32'(b_busy),      32'd0);
    chk("t5_c6_if_rvalid",  32'(b_if_rvalid), 32'd0);
    chk("t5_c6_if_rdata",   b_if_rdata,       32'd112);
    next_cycle();

    // Test 6: reset pulse with two reads in flight on the MEM_LAT=3 instance.
    b_if_req = 1; b_if_addr = 10'd10;
    next_cycle();
    b_if_req = 0; b_d_req = 1; b_d_addr = 10'd11;
    next_cycle();
    b_if_req = 1; b_if_addr = 10'd12;
    rst_n = 0;
    #1;
    b_check_all_zero("t6_rst");
    b_idle();
    next_cycle();
    next_cycle();
    rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("t6_c%0d_if_rvalid", c), 32'(b_if_rvalid), 32'd0);
      chk($sformatf("t6_c%0d_d_rvalid", c),  32'(b_d_rvalid),  32'd0);
      chk($sformatf("t6_c%0d_busy", c),      32'(b_busy),      32'd0);
      next_cycle();
    end
    // Starve counter restarts from 0: four data grants before the forced fetch.
    b_if_req = 1; b_if_addr = 10'd1;
    b_d_req = 1; b_d_we = 1; b_d_addr = 10'd40; b_d_wdata = 32'h5;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("t6_s%0d_if_gnt", c), 32'(b_if_gnt), (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("t6_s%0d_d_gnt", c),  32'(b_d_gnt),  (c == 4) ? 32'd0 : 32'd1);
      next_cycle();
    end
    b_idle();
    repeat (4) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Grants must never coincide on either instance.
  always @(negedge clk) begin
    if (rst_n && a_if_gnt && a_d_gnt) begin
      failures++;
      $display("FAIL dual_grant_a: if_gnt=1 d_gnt=1 expected at most one at %0t", $time);
    end
    if (rst_n && b_if_gnt && b_d_gnt) begin
      failures++;
      $display("FAIL dual_grant_b: if_gnt=1 d_gnt=1 expected at most one at %0t", $time);
    end
  end

endmodule
